// File: rtl/codec_intf.sv
`timescale 1ns/1ps
// I2S link between the stereo codec and the equalizer core: divides clk into
// MCLK/SCLK/LRCLK, deserializes ADC data into sample pairs, serializes DAC data.
module codec_intf (
  input  logic        clk,
  input  logic        rst,
  output logic        LRCLK,
  output logic        SCLK,
  output logic        MCLK,
  output logic        RSTn,
  input  logic        SDout,
  output logic        SDin,
  input  logic [15:0] lft_out,
  input  logic [15:0] rht_out,
  output logic [15:0] lft_in,
  output logic [15:0] rht_in,
  output logic        valid
);

  logic [9:0]  cnt_q, cnt_d;
  logic        rstn_q, sdin_q, valid_q, lft_seen_q;
  logic [15:0] rx_l_q, rx_r_q, hold_l_q;
  logic [15:0] tx_l_q, tx_r_q;
  logic [15:0] lft_in_q, rht_in_q;

  logic [4:0]  k_q, k_d;
  logic        rx_bit;
  logic [15:0] lft_word_d, rht_word_d, tx_buf;
  logic [3:0]  tx_idx;
  logic        sdin_d;

  assign cnt_d = cnt_q + 10'd1;
  assign k_q   = cnt_q[8:4];
  assign k_d   = cnt_d[8:4];

  // Data sits one slot after the LRCLK edge, so slots 1..16 carry MSB..LSB.
  assign rx_bit     = (cnt_q[3:0] == 4'h7) && (k_q >= 5'd1) && (k_q <= 5'd16);
  assign lft_word_d = {rx_l_q[14:0], SDout};
  assign rht_word_d = {rx_r_q[14:0], SDout};

  // Bit 16-k of the buffer; the 4-bit wrap maps k=16 onto bit 0.
  assign tx_buf = cnt_d[9] ? tx_r_q : tx_l_q;
  assign tx_idx = 4'd0 - k_d[3:0];
  assign sdin_d = (k_d >= 5'd1) && (k_d <= 5'd16) && tx_buf[tx_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 10'h200;
      rstn_q     <= 1'b0;
      sdin_q     <= 1'b0;
      valid_q    <= 1'b0;
      lft_seen_q <= 1'b0;
      rx_l_q     <= '0;
      rx_r_q     <= '0;
      hold_l_q   <= '0;
      tx_l_q     <= '0;
      tx_r_q     <= '0;
      lft_in_q   <= '0;
      rht_in_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      rstn_q  <= 1'b1;
      valid_q <= 1'b0;
      if (rx_bit) begin
        if (cnt_q[9]) rx_r_q <= rht_word_d;
        else          rx_l_q <= lft_word_d;
      end
      if (cnt_q == 10'h107) begin
        hold_l_q   <= lft_word_d;
        lft_seen_q <= 1'b1;
      end
      // A right word without a preceding left word is dropped silently.
      if (cnt_q == 10'h307) begin
        valid_q <= lft_seen_q;
        if (lft_seen_q) begin
          lft_in_q <= hold_l_q;
          rht_in_q <= rht_word_d;
        end
      end
      if (cnt_q == 10'h3FF) begin
        tx_l_q <= lft_out;
        tx_r_q <= rht_out;
      end
      if (cnt_q[3:0] == 4'hF) sdin_q <= sdin_d;
    end
  end

  assign LRCLK  = cnt_q[9];
  assign SCLK   = cnt_q[3];
  assign MCLK   = cnt_q[1];
  assign RSTn   = rstn_q;
  assign SDin   = sdin_q;
  assign valid  = valid_q;
  assign lft_in = lft_in_q;
  assign rht_in = rht_in_q;

endmodule

// File: tb/tb_codec_intf.sv
`timescale 1ns/1ps
// Bench for codec_intf: codec model on SDout, expected sample pairs queued by a
// frame model and popped by a monitor on valid; SDin decoded on SCLK rises.
module tb_codec_intf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        LRCLK, SCLK, MCLK, RSTn, SDin, valid;
  logic        SDout = 1'b0;
  logic [15:0] lft_out, rht_out, lft_in, rht_in;

  codec_intf dut (
    .clk(clk), .rst(rst), .LRCLK(LRCLK), .SCLK(SCLK), .MCLK(MCLK), .RSTn(RSTn),
    .SDout(SDout), .SDin(SDin), .lft_out(lft_out), .rht_out(rht_out),
    .lft_in(lft_in), .rht_in(rht_in), .valid(valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // frame model state
  logic [9:0]  m_cnt;
  int          rel;
  int          wraps;
  logic        lseen;
  logic [15:0] tx_el, tx_er;
  logic [15:0] codec_l, codec_r;

  // expected-sample queue (producer owns wp, monitor owns rp)
  logic [15:0] q_l [8];
  logic [15:0] q_r [8];
  int          q_t [8];
  int          wp, rp;

  int          clk_bad = 0, hold_bad = 0, zero_bad = 0;
  logic [15:0] held_l, held_r;
  int          nv = 0;
  int          vt [8];
  logic [15:0] vl [8];
  logic [15:0] vr [8];
  logic [15:0] dl [8];
  logic [15:0] dr [8];
  logic [15:0] sh;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic reset_checks();
    chk("rst_ctl", 32'({LRCLK, SCLK, MCLK, RSTn, SDin, valid}), 32'b100000);
    chk("rst_lft_in", 32'(lft_in), 32'h0);
    chk("rst_rht_in", 32'(rht_in), 32'h0);
  endtask

  // Frame model: counter, tx latch at wrap, expected pairs on right completion.
  initial begin
    m_cnt = 10'h200; rel = 0; wp = 0; wraps = 0; lseen = 1'b0; tx_el = '0; tx_er = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_cnt = 10'h200; rel = 0; wp = 0; wraps = 0; lseen = 1'b0; tx_el = '0; tx_er = '0;
      end else begin
        if (m_cnt == 10'h3FF) begin
          tx_el = lft_out; tx_er = rht_out; wraps++;
        end
        if (m_cnt == 10'h107) lseen = 1'b1;
        if (m_cnt == 10'h307 && lseen) begin
          q_l[wp % 8] = codec_l; q_r[wp % 8] = codec_r; q_t[wp % 8] = rel + 1; wp++;
        end
        m_cnt = m_cnt + 10'd1;
        rel++;
      end
    end
  end

  // Codec ADC model: I2S-aligned, MSB in slot 1.
  initial begin
    forever begin
      logic [4:0]  k;
      logic [15:0] w;
      @(negedge clk);
      k = m_cnt[8:4];
      w = m_cnt[9] ? codec_r : codec_l;
      SDout = (k >= 5'd1 && k <= 5'd16) ? w[16 - int'(k)] : 1'b0;
    end
  end

  // Monitor: scoreboard pops, held-output checks, clock checks, SDin decode.
  initial begin
    rp = 0; held_l = '0; held_r = '0; sh = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rp = 0; held_l = '0; held_r = '0;
      end else begin
        if ({LRCLK, SCLK, MCLK, RSTn} !== {m_cnt[9], m_cnt[3], m_cnt[1], 1'b1}) clk_bad++;
        if (valid === 1'b1) begin
          if (wp == rp) chk("unexpected_valid", 32'(valid), 32'h0);
          else begin
            chk("valid_time", 32'(rel), 32'(q_t[rp % 8]));
            chk("lft_in", 32'(lft_in), 32'(q_l[rp % 8]));
            chk("rht_in", 32'(rht_in), 32'(q_r[rp % 8]));
            held_l = q_l[rp % 8]; held_r = q_r[rp % 8];
            rp++;
          end
          if (nv < 8) begin vt[nv] = rel; vl[nv] = lft_in; vr[nv] = rht_in; end
          nv++;
        end else if (lft_in !== held_l || rht_in !== held_r) hold_bad++;
        if (m_cnt[3:0] == 4'h7) begin
          if (m_cnt[8:4] >= 5'd1 && m_cnt[8:4] <= 5'd16) begin
            sh = {sh[14:0], SDin};
            if (m_cnt[8:4] == 5'd16) begin
              if (!m_cnt[9]) begin
                chk("tx_left", 32'(sh), 32'(tx_el));
                if (wraps < 8) dl[wraps] = sh;
              end else begin
                chk("tx_right", 32'(sh), 32'(tx_er));
                if (wraps < 8) dr[wraps] = sh;
              end
            end
          end else if (SDin !== 1'b0) zero_bad++;
        end
      end
    end
  end

  initial begin
    lft_out = 16'h8001; rht_out = 16'h7FFE;
    codec_l = 16'hA5C3; codec_r = 16'h1234;
    repeat (3) @(negedge clk);
    reset_checks();
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rstn_release", 32'(RSTn), 32'h1);
    while (rel < 511) @(negedge clk);
    chk("lrclk_511", 32'(LRCLK), 32'h1);
    @(negedge clk);
    chk("lrclk_512", 32'(LRCLK), 32'h0);
    while (rel < 592) @(negedge clk);
    chk("cnt_at_change", 32'(m_cnt), 32'h050);
    lft_out = 16'h00FF;
    while (rel < 2400) @(negedge clk);

    chk("first_valid_t", 32'(vt[0]), 32'd1288);
    chk("first_lft", 32'(vl[0]), 32'hA5C3);
    chk("first_rht", 32'(vr[0]), 32'h1234);
    chk("second_valid_t", 32'(vt[1]), 32'd2312);
    chk("valid_count", 32'(nv), 32'd2);
    chk("tx_reset_half_r", 32'(dr[0]), 32'h0);
    chk("tx_frame1_l", 32'(dl[1]), 32'h8001);
    chk("tx_frame1_r", 32'(dr[1]), 32'h7FFE);
    chk("tx_frame2_l", 32'(dl[2]), 32'h00FF);
    chk("clkgen", 32'(clk_bad), 32'h0);
    chk("hold", 32'(hold_bad), 32'h0);
    chk("sdin_zero_slots", 32'(zero_bad), 32'h0);

    for (int i = 0; i < 1100 && m_cnt != 10'h0A0; i++) @(negedge clk);
    chk("reach_0A0", 32'(m_cnt), 32'h0A0);
    #2 rst = 1'b1;
    #1 reset_checks();
    codec_l = 16'h5A3C; codec_r = 16'h0F0F;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    while (rel < 1300) @(negedge clk);

    chk("post_rst_valid_t", 32'(vt[2]), 32'd1288);
    chk("post_rst_lft", 32'(vl[2]), 32'h5A3C);
    chk("post_rst_rht", 32'(vr[2]), 32'h0F0F);
    chk("valid_count_end", 32'(nv), 32'd3);
    chk("pending", 32'(wp - rp), 32'h0);
    chk("clkgen_end", 32'(clk_bad), 32'h0);
    chk("hold_end", 32'(hold_bad), 32'h0);
    chk("sdin_zero_end", 32'(zero_bad), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
